// File: rtl/apb_master_if.sv
// APB bus bundle between one requester-side master and a completer.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// Valid/ready request -> single APB transfer -> valid/ready response; min latency 3 cycles.
// One transfer in flight; req_ready only in IDLE, response held until rsp_ready.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    apb_if.master                 apb_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic accept;
    logic aligned;
    logic xfer_done;
    logic tmo;

    assign aligned = (req_addr[1:0] == 2'b00);

    // Next-state and transfer strobes; APB inputs only matter in ACCESS.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        xfer_done = 1'b0;
        tmo       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = aligned ? SETUP : RESP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb_out.pready) begin
                    xfer_done = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address phase registers stay frozen from SETUP through the last ACCESS cycle.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (accept && aligned) begin
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else if (accept && aligned) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !xfer_done && !tmo) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response payload is only written on entry to RESP, so it holds while stalled.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && !aligned) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (xfer_done) begin
            err_q   <= apb_out.pslverr;
            rdata_q <= (!pwrite_q && !apb_out.pslverr) ? apb_out.prdata : '0;
        end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign apb_out.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb_out.penable = (state_q == ACCESS);
    assign apb_out.pwrite  = pwrite_q;
    assign apb_out.paddr   = paddr_q;
    assign apb_out.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomised and directed bench for apb_master with a behavioural APB completer.
module tb_apb_master;

    localparam int TMO = 4;

    logic        clk;
    logic        arstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb_out   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completer: ready after cfg_wait wait states; random junk outside ACCESS.
    int          cfg_wait;
    logic [31:0] cfg_rdata;
    logic        cfg_err;
    int          acc_cnt;
    logic        junk_rdy;
    logic        junk_err;
    logic [31:0] junk_dat;
    logic        in_acc;
    logic        hit;

    assign in_acc      = bus.psel && bus.penable;
    assign hit         = in_acc && (acc_cnt == cfg_wait);
    assign bus.pready  = in_acc ? hit : junk_rdy;
    assign bus.prdata  = hit ? cfg_rdata : junk_dat;
    assign bus.pslverr = hit ? cfg_err : junk_err;

    always @(posedge clk) acc_cnt <= (in_acc && !bus.pready) ? acc_cnt + 1 : 0;
    always @(negedge clk) begin
        junk_rdy <= 1'($urandom);
        junk_err <= 1'($urandom);
        junk_dat <= $urandom;
    end

    int pass_cnt;
    int total_cnt;

    typedef struct {
        bit          done;
        int          setup;
        int          access;
        int          lat;
        bit          addr_ok;
        bit          stable;
        bit          rr_low;
        bit          bus_idle;
        logic [31:0] rdata;
        logic        err;
        logic        rr_after;
        logic        rv_after;
    } obs_t;

    typedef struct {
        int          setup;
        int          access;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    // Reference: what a single request should produce, from the protocol rules.
    function automatic exp_t model(logic [31:0] addr, bit wr, int waits, bit slv, logic [31:0] rd);
        exp_t e;
        bit   timed;
        if (addr % 4 != 0) begin
            e.setup = 0; e.access = 0; e.lat = 1; e.rdata = 0; e.err = 1'b1;
            return e;
        end
        timed    = (waits >= TMO);
        e.setup  = 1;
        e.access = timed ? TMO : waits + 1;
        e.err    = timed || slv;
        e.rdata  = (!wr && !e.err) ? rd : 32'h0;
        e.lat    = 2 + e.access;
        return e;
    endfunction

    // Drives one request from a negedge and observes it until the response is consumed.
    task automatic do_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd, input bit slv,
                          input int hold, output obs_t o);
        o = '{default: 0};
        o.addr_ok = 1; o.stable = 1; o.rr_low = 1; o.bus_idle = 1;
        cfg_wait = waits; cfg_rdata = rd; cfg_err = slv;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) return;
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
        o.lat = 1;
        while (!rsp_valid && o.lat < 40) begin
            if (bus.psel) begin
                if (!bus.penable) o.setup++;
                else begin
                    o.access++;
                    if (o.setup == 0) o.addr_ok = 0;
                end
                if (bus.paddr !== addr || bus.pwrite !== wr || (wr && bus.pwdata !== wdata))
                    o.addr_ok = 0;
            end else if (bus.penable) o.addr_ok = 0;
            @(negedge clk);
            o.lat++;
        end
        if (!rsp_valid) return;
        o.done = 1; o.rdata = rsp_rdata; o.err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (bus.psel || bus.penable) o.bus_idle = 0;
            if (req_ready) o.rr_low = 0;
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== o.rdata || rsp_err !== o.err) o.stable = 0;
        end
        if (bus.psel || bus.penable) o.bus_idle = 0;
        if (req_ready) o.rr_low = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o.rr_after = req_ready;
        o.rv_after = rsp_valid;
    endtask

    task automatic test_reset();
        arstn = 1'b1;
        #2 arstn = 1'b0;
        #2;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %0b want 1", req_ready); else pass_cnt++;
        total_cnt++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) $display("FAIL rst_ctrl: got %b want 000", {bus.psel, bus.penable, bus.pwrite}); else pass_cnt++;
        total_cnt++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) $display("FAIL rst_addr_data: got %h/%h want 0/0", bus.paddr, bus.pwdata); else pass_cnt++;
        total_cnt++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 32'h0) $display("FAIL rst_rsp: got v%0b e%0b d%h want 0", rsp_valid, rsp_err, rsp_rdata); else pass_cnt++;
        @(negedge clk) arstn = 1'b1;
        @(negedge clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_write();
        obs_t o;
        do_txn(32'h0, 1'b1, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 0, o);
        total_cnt++; if (!o.done) $display("FAIL wr_done: no response within budget"); else pass_cnt++;
        total_cnt++; if (o.setup != 1 || o.access != 1) $display("FAIL wr_phases: got setup %0d access %0d want 1/1", o.setup, o.access); else pass_cnt++;
        total_cnt++; if (o.lat != 3) $display("FAIL wr_latency: got %0d want 3", o.lat); else pass_cnt++;
        total_cnt++; if (o.err !== 1'b0 || o.rdata !== 32'h0) $display("FAIL wr_rsp: got e%0b d%h want e0 d0", o.err, o.rdata); else pass_cnt++;
        total_cnt++; if (!o.addr_ok) $display("FAIL wr_bus: address/data/control not held as issued"); else pass_cnt++;
    endtask

    task automatic test_wait_read();
        obs_t o;
        do_txn(32'h8, 1'b0, 32'h0, 3, 32'hA5A5_5A5A, 1'b0, 0, o);
        total_cnt++; if (o.access != 4) $display("FAIL rd_wait_penable: got %0d cycles want 4", o.access); else pass_cnt++;
        total_cnt++; if (!o.addr_ok) $display("FAIL rd_wait_paddr: PADDR/PWRITE moved during transfer"); else pass_cnt++;
        total_cnt++; if (o.rdata !== 32'hA5A5_5A5A || o.err !== 1'b0) $display("FAIL rd_wait_data: got e%0b d%h want e0 dA5A55A5A", o.err, o.rdata); else pass_cnt++;
    endtask

    task automatic test_slverr();
        obs_t o;
        do_txn(32'h10, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 0, o);
        total_cnt++; if (o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL slverr_rsp: got e%0b d%h want e1 d0", o.err, o.rdata); else pass_cnt++;
        total_cnt++; if (o.access != 2) $display("FAIL slverr_access: got %0d want 2", o.access); else pass_cnt++;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(32'h20, 1'b0, 32'h0, 1000, 32'h1234_5678, 1'b0, 1, o);
        total_cnt++; if (o.access != TMO) $display("FAIL tmo_access: got %0d want %0d", o.access, TMO); else pass_cnt++;
        total_cnt++; if (!o.bus_idle) $display("FAIL tmo_psel_drop: PSEL/PENABLE high during response"); else pass_cnt++;
        total_cnt++; if (o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL tmo_rsp: got e%0b d%h want e1 d0", o.err, o.rdata); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_txn(32'h2, 1'b1, 32'h5555_AAAA, 0, 32'h0, 1'b0, 5, o);
        total_cnt++; if (o.setup != 0 || o.access != 0) $display("FAIL mis_no_apb: got setup %0d access %0d want 0/0", o.setup, o.access); else pass_cnt++;
        total_cnt++; if (o.lat != 1) $display("FAIL mis_latency: got %0d want 1", o.lat); else pass_cnt++;
        total_cnt++; if (o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL mis_rsp: got e%0b d%h want e1 d0", o.err, o.rdata); else pass_cnt++;
        total_cnt++; if (!o.stable) $display("FAIL mis_hold_stable: response changed while stalled"); else pass_cnt++;
        total_cnt++; if (!o.rr_low) $display("FAIL mis_hold_ready: req_ready rose while response pending"); else pass_cnt++;
        total_cnt++; if (o.rr_after !== 1'b1 || o.rv_after !== 1'b0) $display("FAIL mis_release: got rr%0b rv%0b want rr1 rv0", o.rr_after, o.rv_after); else pass_cnt++;
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] addr, wdata, rd;
        bit          wr, slv;
        int          waits, hold;
        for (int n = 0; n < 40; n++) begin
            addr  = {$urandom_range(0, 255), 2'b00} | ((($urandom_range(0, 3) == 0)) ? 32'($urandom_range(1, 3)) : 32'h0);
            wr    = 1'($urandom);
            wdata = $urandom;
            rd    = $urandom;
            slv   = ($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 6);
            hold  = $urandom_range(0, 2);
            e = model(addr, wr, waits, slv, rd);
            do_txn(addr, wr, wdata, waits, rd, slv, hold, o);
            total_cnt++; if (!o.done || o.err !== e.err || o.rdata !== e.rdata)
                $display("FAIL rnd_rsp[%0d]: got done%0b e%0b d%h want e%0b d%h", n, o.done, o.err, o.rdata, e.err, e.rdata); else pass_cnt++;
            total_cnt++; if (o.setup != e.setup || o.access != e.access || o.lat != e.lat)
                $display("FAIL rnd_timing[%0d]: got s%0d a%0d l%0d want s%0d a%0d l%0d", n, o.setup, o.access, o.lat, e.setup, e.access, e.lat); else pass_cnt++;
            total_cnt++; if (!o.addr_ok || !o.stable || !o.rr_low || !o.bus_idle || o.rr_after !== 1'b1)
                $display("FAIL rnd_protocol[%0d]: got bus%0b stab%0b rrlow%0b idle%0b rr%0b want all 1", n, o.addr_ok, o.stable, o.rr_low, o.bus_idle, o.rr_after); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        do_txn(32'h100, 1'b1, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 0, o1);
        do_txn(32'h104, 1'b0, 32'h0, 2, 32'hCAFE_0001, 1'b0, 0, o2);
        total_cnt++; if (o1.rr_after !== 1'b1) $display("FAIL b2b_ready_return: got %0b want 1", o1.rr_after); else pass_cnt++;
        total_cnt++; if (o2.lat != 5 || o2.rdata !== 32'hCAFE_0001) $display("FAIL b2b_second: got l%0d d%h want l5 dCAFE0001", o2.lat, o2.rdata); else pass_cnt++;
    endtask

    task automatic test_reset_in_access();
        bit seen;
        cfg_wait = 1000;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h40; req_write = 1'b1; req_wdata = 32'h7777_0000;
        @(negedge clk) req_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.penable !== 1'b1) $display("FAIL rst_acc_reach: got penable %0b want 1", bus.penable); else pass_cnt++;
        #2 arstn = 1'b0;
        #1;
        total_cnt++; if ({bus.psel, bus.penable, rsp_valid} !== 3'b000) $display("FAIL rst_acc_async: got %b want 000", {bus.psel, bus.penable, rsp_valid}); else pass_cnt++;
        total_cnt++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) $display("FAIL rst_acc_regs: got %h/%h want 0/0", bus.paddr, bus.pwdata); else pass_cnt++;
        @(negedge clk);
        @(negedge clk) arstn = 1'b1;
        cfg_wait = 0;
        seen = 0;
        @(negedge clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_acc_ready: got %0b want 1", req_ready); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || bus.psel) seen = 1;
            @(negedge clk);
        end
        total_cnt++; if (seen) $display("FAIL rst_acc_no_rsp: activity after reset release"); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        cfg_wait = 0; cfg_rdata = 32'h0; cfg_err = 1'b0;
        test_reset();
        test_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_misaligned();
        test_random();
        test_back_to_back();
        test_reset_in_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
